inst_sequencer: RTL and testbench

Instruction sequencer that produces the 34-bit instruction word and the mode/sel/tile/relu side-band for the dual-core tiled datapath. It is the initiator of that instruction interface; the dual core is the responder. For each kernel position (kij) it runs weight load, activation execute, and ofifo-to-psum-SRAM writeback, ping-ponging the psum banks and enabling accumulation after the first kij. Host or testbench supplies a configuration and a `start` pulse.

---
 rtl/inst_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_inst_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Instruction sequencer for the dual-core tiled datapath: per kernel position it
// issues weight load, activation execute and ofifo-to-psum writeback words.
module inst_sequencer #(
  parameter int row   = 2,
  parameter int col   = 2,
  parameter int drain = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cfg_num_kij,
  input  logic [10:0] cfg_num_nij,
  input  logic [10:0] cfg_w_base,
  input  logic [10:0] cfg_a_base,
  input  logic [10:0] cfg_o_base,
  input  logic [1:0]  cfg_tile,
  input  logic        cfg_mode,
  input  logic        cfg_relu,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        mode,
  output logic        sel,
  output logic        relu,
  output logic [1:0]  tile,
  output logic        busy,
  output logic        done
);
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_XRD, S_W_LOAD, S_W_DRAIN, S_A_XRD, S_A_EXEC, S_A_DRAIN, S_O_WB, S_DONE
  } state_t;

  state_t      r_state, w_state_nx;
  logic [11:0] r_cnt, w_cnt_nx;
  logic [10:0] r_j, w_j_nx, w_jaddr;
  logic [3:0]  r_k, w_k_nx;
  logic        r_sel, w_sel_nx, r_zero, w_zero_nx, w_beat, w_start;
  logic [3:0]  r_num_kij, w_num_kij;
  logic [10:0] r_num_nij, w_num_nij, r_w_base, w_w_base, r_a_base, w_a_base, r_o_base, w_o_base;
  logic [1:0]  r_tile_cfg, w_tile_cfg;
  logic        r_mode_cfg, w_mode_cfg, r_relu_cfg, w_relu_cfg;
  logic [33:0] r_inst, w_inst_nx;
  logic [10:0] w_kxr;
  logic        r_mode, r_relu, r_busy, r_done;
  logic [1:0]  r_tile;

  // Configuration as seen by the next cycle: fresh inputs on the accepting edge.
  always_comb begin
    w_start    = (r_state == S_IDLE) && start;
    w_num_kij  = w_start ? cfg_num_kij : r_num_kij;
    w_num_nij  = w_start ? cfg_num_nij : r_num_nij;
    w_w_base   = w_start ? cfg_w_base  : r_w_base;
    w_a_base   = w_start ? cfg_a_base  : r_a_base;
    w_o_base   = w_start ? cfg_o_base  : r_o_base;
    w_tile_cfg = w_start ? cfg_tile    : r_tile_cfg;
    w_mode_cfg = w_start ? cfg_mode    : r_mode_cfg;
    w_relu_cfg = w_start ? cfg_relu    : r_relu_cfg;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 12'd1;
    w_j_nx     = r_j;
    w_jaddr    = r_j;
    w_k_nx     = r_k;
    w_sel_nx   = r_sel;
    w_zero_nx  = r_zero;
    w_beat     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nx = S_W_XRD;
        w_cnt_nx   = 12'd0;
        w_k_nx     = 4'd0;
        w_sel_nx   = 1'b0;
        w_zero_nx  = (cfg_num_kij == 4'd0) || (cfg_num_nij == 11'd0);
      end
      S_W_XRD: if (r_zero) begin
        w_state_nx = S_DONE;
      end else if (r_cnt == 12'(row)) begin
        w_state_nx = S_W_LOAD;
        w_cnt_nx   = 12'd0;
      end
      S_W_LOAD: if (r_cnt == 12'(col - 1)) begin
        w_state_nx = S_W_DRAIN;
        w_cnt_nx   = 12'd0;
      end
      S_W_DRAIN: if (r_cnt == 12'(drain - 1)) begin
        w_state_nx = S_A_XRD;
        w_cnt_nx   = 12'd0;
      end
      S_A_XRD: if (r_cnt == {1'b0, r_num_nij}) begin
        w_state_nx = S_A_EXEC;
        w_cnt_nx   = 12'd0;
      end
      S_A_EXEC: if (r_cnt == {1'b0, r_num_nij} - 12'd1) begin
        w_state_nx = S_A_DRAIN;
        w_cnt_nx   = 12'd0;
      end
      S_A_DRAIN: if (r_cnt == 12'(drain - 1)) begin
        w_state_nx = S_O_WB;
        w_cnt_nx   = 12'd0;
        w_beat     = ofifo_valid;
        w_jaddr    = 11'd0;
        w_j_nx     = {10'd0, ofifo_valid};
      end
      // r_j counts beats already placed on inst, so equality means the last one is out.
      S_O_WB: if (r_j == r_num_nij) begin
        if (r_k == r_num_kij - 4'd1) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_W_XRD;
          w_cnt_nx   = 12'd0;
          w_k_nx     = r_k + 4'd1;
          w_sel_nx   = ~r_sel;
        end
      end else begin
        w_beat = ofifo_valid;
        if (ofifo_valid) w_j_nx = r_j + 11'd1;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Word for the next cycle, built from the next state so every output is registered.
  always_comb begin
    w_inst_nx = IDLE_WORD;
    w_kxr     = 11'(w_k_nx) * 11'(row);
    case (w_state_nx)
      S_W_XRD: if (!w_zero_nx) begin
        if (w_cnt_nx < 12'(row)) begin
          w_inst_nx[19]   = 1'b0;
          w_inst_nx[17:7] = w_w_base + w_kxr + w_cnt_nx[10:0];
        end
        w_inst_nx[2] = (w_cnt_nx != 12'd0);
      end
      S_W_LOAD: begin
        w_inst_nx[0] = 1'b1;
        w_inst_nx[3] = 1'b1;
      end
      S_A_XRD: begin
        if (w_cnt_nx < {1'b0, w_num_nij}) begin
          w_inst_nx[19]   = 1'b0;
          w_inst_nx[17:7] = w_a_base + w_cnt_nx[10:0];
        end
        w_inst_nx[2] = (w_cnt_nx != 12'd0);
      end
      S_A_EXEC: begin
        w_inst_nx[1] = 1'b1;
        w_inst_nx[3] = 1'b1;
      end
      S_O_WB: if (w_beat) begin
        w_inst_nx[33]    = (w_k_nx != 4'd0);
        w_inst_nx[32]    = 1'b0;
        w_inst_nx[31]    = 1'b0;
        w_inst_nx[30:20] = w_o_base + w_jaddr;
        w_inst_nx[6]     = 1'b1;
      end
      default: w_inst_nx = IDLE_WORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 12'd0;
      r_j        <= 11'd0;
      r_k        <= 4'd0;
      r_sel      <= 1'b0;
      r_zero     <= 1'b0;
      r_num_kij  <= 4'd0;
      r_num_nij  <= 11'd0;
      r_w_base   <= 11'd0;
      r_a_base   <= 11'd0;
      r_o_base   <= 11'd0;
      r_tile_cfg <= 2'd0;
      r_mode_cfg <= 1'b0;
      r_relu_cfg <= 1'b0;
      r_inst     <= IDLE_WORD;
      r_mode     <= 1'b0;
      r_tile     <= 2'd0;
      r_relu     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_j        <= w_j_nx;
      r_k        <= w_k_nx;
      r_sel      <= w_sel_nx;
      r_zero     <= w_zero_nx;
      r_num_kij  <= w_num_kij;
      r_num_nij  <= w_num_nij;
      r_w_base   <= w_w_base;
      r_a_base   <= w_a_base;
      r_o_base   <= w_o_base;
      r_tile_cfg <= w_tile_cfg;
      r_mode_cfg <= w_mode_cfg;
      r_relu_cfg <= w_relu_cfg;
      r_inst     <= w_inst_nx;
      r_busy     <= (w_state_nx != S_IDLE);
      r_done     <= (w_state_nx == S_DONE);
      r_mode     <= (w_state_nx != S_IDLE) && w_mode_cfg;
      r_tile     <= (w_state_nx != S_IDLE) ? w_tile_cfg : 2'd0;
      r_relu     <= (w_state_nx == S_O_WB) && (w_k_nx == w_num_kij - 4'd1) && w_relu_cfg;
    end
  end

  assign inst = r_inst;
  assign mode = r_mode;
  assign sel  = r_sel;
  assign relu = r_relu;
  assign tile = r_tile;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized bench for inst_sequencer: a cycle-list reference model built from the
// phase lengths and field rules is compared against every output cycle.
module tb_inst_sequencer;
  localparam int ROW = 2, COL = 2, DRAIN = 4;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, ofifo_valid = 1'b0;
  logic [3:0]  cfg_num_kij = '0;
  logic [10:0] cfg_num_nij = '0, cfg_w_base = '0, cfg_a_base = '0, cfg_o_base = '0;
  logic [1:0]  cfg_tile = '0;
  logic        cfg_mode = 1'b0, cfg_relu = 1'b0;
  logic [33:0] inst;
  logic        mode, sel, relu, busy, done;
  logic [1:0]  tile;

  inst_sequencer #(.row(ROW), .col(COL), .drain(DRAIN)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_kij(cfg_num_kij),
    .cfg_num_nij(cfg_num_nij), .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base),
    .cfg_o_base(cfg_o_base), .cfg_tile(cfg_tile), .cfg_mode(cfg_mode),
    .cfg_relu(cfg_relu), .ofifo_valid(ofifo_valid), .inst(inst), .mode(mode),
    .sel(sel), .relu(relu), .tile(tile), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_txn = 0;
  bit vld [8192];
  logic [40:0] expq [$];
  logic        m_mode;
  logic [1:0]  m_tile;

  task automatic chk(input string tag, input logic [40:0] got, input logic [40:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction word assembled field by field.
  function automatic logic [33:0] wd(input logic acc, pc, pw, input logic [10:0] pa,
                                     input logic xc, xw, input logic [10:0] xa,
                                     input logic ofrd, l0rd, l0wr, exe, ld);
    return {acc, pc, pw, pa, xc, xw, xa, ofrd, 2'b00, l0rd, l0wr, exe, ld};
  endfunction

  // Expected cycle record: {done, busy, sel, relu, mode, tile, inst}.
  task automatic push(input logic [33:0] w, input logic s, r, d, b);
    expq.push_back({d, b, s, r, b & m_mode, b ? m_tile : 2'b00, w});
  endtask

  task automatic build(input int kij, nij, input logic [10:0] wb, ab, ob, input logic rl);
    expq.delete();
    if (kij == 0 || nij == 0) begin
      push(IDLE_W, 0, 0, 0, 1);
      push(IDLE_W, 0, 0, 1, 1);
      push(IDLE_W, 0, 0, 0, 0);
      return;
    end
    for (int k = 0; k < kij; k++) begin
      logic s, rk;
      int   j;
      s  = k[0];
      rk = rl && (k == kij - 1);
      for (int i = 0; i <= ROW; i++)
        push(wd(0, 1, 1, 0, (i < ROW) ? 1'b0 : 1'b1, 1, (i < ROW) ? 11'(wb + k * ROW + i) : 11'd0,
                0, 0, i > 0, 0, 0), s, 0, 0, 1);
      for (int i = 0; i < COL; i++) push(wd(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1), s, 0, 0, 1);
      for (int i = 0; i < DRAIN; i++) push(IDLE_W, s, 0, 0, 1);
      for (int i = 0; i <= nij; i++)
        push(wd(0, 1, 1, 0, (i < nij) ? 1'b0 : 1'b1, 1, (i < nij) ? 11'(ab + i) : 11'd0,
                0, 0, i > 0, 0, 0), s, 0, 0, 1);
      for (int i = 0; i < nij; i++) push(wd(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0), s, 0, 0, 1);
      for (int i = 0; i < DRAIN; i++) push(IDLE_W, s, 0, 0, 1);
      // A writeback cycle carries a beat when ofifo_valid was high going into it.
      j = 0;
      while (j < nij) begin
        if (vld[expq.size() - 1]) begin
          push(wd(k != 0, 0, 0, 11'(ob + j), 1, 1, 0, 1, 0, 0, 0, 0), s, rk, 0, 1);
          j++;
        end else begin
          push(IDLE_W, s, rk, 0, 1);
        end
      end
    end
    push(IDLE_W, 1'((kij - 1) % 2), 0, 1, 1);
    push(IDLE_W, 1'((kij - 1) % 2), 0, 0, 0);
  endtask

  // vmode: 0 random valid, 1 always valid, 2 scripted toggle at writeback entry.
  task automatic run(input logic [3:0] kij, input logic [10:0] nij, wb, ab, ob,
                     input logic [1:0] t, input logic m, rl, input int vmode, input int abort_at);
    int errs0, dens;
    dens = $urandom_range(30, 90);
    foreach (vld[i]) vld[i] = (vmode == 0) ? ($urandom_range(0, 99) < dens) : 1'b1;
    if (vmode == 2) begin
      vld[21] = 1; vld[22] = 0; vld[23] = 0; vld[24] = 1;
      vld[25] = 1; vld[26] = 0; vld[27] = 1;
    end
    m_mode = m;
    m_tile = t;
    build(int'(kij), int'(nij), wb, ab, ob, rl);
    errs0 = n_err;
    @(negedge clk);
    cfg_num_kij = kij; cfg_num_nij = nij; cfg_w_base = wb; cfg_a_base = ab;
    cfg_o_base = ob; cfg_tile = t; cfg_mode = m; cfg_relu = rl; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < expq.size(); n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rst", {done, busy, sel, relu, mode, tile, inst}, {7'd0, IDLE_W});
        break;
      end
      chk($sformatf("t%0d_c%0d", n_txn, n), {done, busy, sel, relu, mode, tile, inst}, expq[n]);
      ofifo_valid = vld[n];
      // A second request while busy, with scrambled cfg, must change nothing.
      start = (n == 3);
      if (n == 3) begin
        cfg_num_kij = 4'($urandom); cfg_num_nij = 11'($urandom); cfg_w_base = 11'($urandom);
        cfg_a_base = 11'($urandom); cfg_o_base = 11'($urandom); cfg_tile = 2'($urandom);
        cfg_mode = ~m; cfg_relu = ~rl;
      end
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    $display("txn %0d kij=%0d nij=%0d wb=%0d ab=%0d ob=%0d vmode=%0d cycles=%0d errors=%0d",
             n_txn, kij, nij, wb, ab, ob, vmode, expq.size(), n_err - errs0);
    n_txn++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {done, busy, sel, relu, mode, tile, inst}, {7'd0, IDLE_W});
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", {done, busy, sel, relu, mode, tile, inst}, {7'd0, IDLE_W});

    run(1, 4, 0, 16, 0, 2'b11, 1, 0, 1, -1);
    run(3, 4, 0, 16, 0, 2'b01, 0, 1, 1, -1);
    run(1, 4, 0, 0, 0, 2'b10, 1, 0, 2, -1);
    run(0, 4, 5, 5, 5, 2'b11, 1, 1, 1, -1);
    run(2, 0, 5, 5, 5, 2'b01, 0, 1, 1, -1);
    run(1, 4, 7, 2046, 2045, 2'b11, 0, 1, 1, -1);
    run(1, 4, 0, 16, 0, 2'b11, 1, 0, 1, 15);
    run(2, 3, 2047, 9, 2046, 2'b10, 1, 1, 0, -1);
    for (int r = 0; r < 10; r++)
      run(4'($urandom_range(0, 5)), 11'($urandom_range(0, 20)), 11'($urandom),
          11'($urandom), 11'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
